// File: rtl/egg_axil_pkg.sv
// Shared constants, FSM state types and address helper for the EggNet AXI4-Lite register file.
package egg_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // W_ADDR / W_DATA record which half of a write has been latched so far
    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_ADDR = 2'b01,
        W_DATA = 2'b10,
        W_RESP = 2'b11
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/egg_axil_regfile_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register file (slave).
interface egg_axil_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID,    output WREADY,
        output BRESP, BVALID,           input  BREADY,
        input  ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID,    input  RREADY
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID,    input  WREADY,
        input  BRESP, BVALID,           output BREADY,
        output ARADDR, ARPROT, ARVALID, input  ARREADY,
        input  RDATA, RRESP, RVALID,    output RREADY
    );

endinterface

// File: rtl/egg_axil_regfile.sv
// Parametrised AXI4-Lite control/status register file with byte strobes, read-only
// status lanes, SLVERR on out-of-range indices and a per-register write pulse.
module egg_axil_regfile
    import egg_axil_pkg::*;
#(
    parameter int                  NUM_REGS   = 4,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    egg_axil_if.slave                      S_AXI,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

    wr_state_t             r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [IDX_W-1:0]      r_awidx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [NUM_REGS-1:0]   r_wr_pulse;
    rd_state_t             r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic                  w_wr_in_range;
    logic [NUM_REGS-1:0]   w_reg_we;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    assign w_aw_hs = S_AXI.AWVALID && r_awready;
    assign w_w_hs  = S_AXI.WVALID && r_wready;
    assign w_ar_hs = S_AXI.ARVALID && r_arready;

    // A write commits on the edge that completes the later of the AW/W handshakes
    assign w_commit = ((r_wstate == W_IDLE) && w_aw_hs && w_w_hs) ||
                      ((r_wstate == W_ADDR) && w_w_hs) ||
                      ((r_wstate == W_DATA) && w_aw_hs);

    assign w_wr_idx  = (r_wstate == W_ADDR) ? r_awidx : S_AXI.AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign w_wr_data = (r_wstate == W_DATA) ? r_wdata : S_AXI.WDATA;
    assign w_wr_strb = (r_wstate == W_DATA) ? r_wstrb : S_AXI.WSTRB;
    assign w_rd_idx  = S_AXI.ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    assign w_wr_in_range = ({1'b0, w_wr_idx} < NUM_REGS_L);
    assign w_rd_in_range = ({1'b0, w_rd_idx} < NUM_REGS_L);

    assign w_unused = ^{S_AXI.AWPROT, S_AXI.ARPROT, S_AXI.AWADDR[ADDR_LSB-1:0],
                        S_AXI.ARADDR[ADDR_LSB-1:0], status_in};

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign w_reg_we[gi] = w_commit && (w_wr_idx == IDX_W'(gi)) && !RO_MASK[gi];

        for (genvar gb = 0; gb < STRB_W; gb++) begin : g_lane
            logic [7:0] r_byte;

            // Byte lane storage; RO registers never see a write enable and stay at zero
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    r_byte <= 8'h00;
                end else if (w_reg_we[gi] && w_wr_strb[gb]) begin
                    r_byte <= w_wr_data[gb*8 +: 8];
                end else begin
                    r_byte <= r_byte;
                end
            end

            assign ctrl_out[gi*DATA_WIDTH + gb*8 +: 8] = r_byte;
        end
    end

    // Read mux: RO lanes come from status_in, out-of-range indices read as zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rd_data = (w_rd_idx == IDX_W'(i))
                      ? (RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH]
                                    : ctrl_out[i*DATA_WIDTH +: DATA_WIDTH])
                      : w_rd_data;
        end
    end

    // Write channel FSM: AW and W may arrive in either order or together
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_reg_we;
            if (w_commit) begin
                r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                r_bresp <= r_bresp;
            end
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                    end else if (w_aw_hs) begin
                        r_wstate  <= W_ADDR;
                        r_awidx   <= w_wr_idx;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_DATA;
                        r_wdata   <= S_AXI.WDATA;
                        r_wstrb   <= S_AXI.WSTRB;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_ADDR: begin
                    if (w_w_hs) begin
                        r_wstate <= W_RESP;
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                    end else begin
                        r_wstate <= W_ADDR;
                    end
                end
                W_DATA: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_bvalid  <= 1'b1;
                    end else begin
                        r_wstate <= W_DATA;
                    end
                end
                W_RESP: begin
                    if (S_AXI.BREADY) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end else begin
                        r_wstate <= W_RESP;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: data is captured at the AR handshake and held until RREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI.RREADY) begin
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end else begin
                        r_rstate <= R_DATA;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI.AWREADY = r_awready;
    assign S_AXI.WREADY  = r_wready;
    assign S_AXI.BVALID  = r_bvalid;
    assign S_AXI.BRESP   = r_bresp;
    assign S_AXI.ARREADY = r_arready;
    assign S_AXI.RVALID  = r_rvalid;
    assign S_AXI.RRESP   = r_rresp;
    assign S_AXI.RDATA   = r_rdata;
    assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_egg_axil_regfile.sv
// Scoreboard bench: one all-RW instance and one with register 2 read-only, driven in lockstep.
module tb_egg_axil_regfile;
    import egg_axil_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*DW-1:0] ctrl0, ctrl1, status;
    logic [NR-1:0]    pulse0, pulse1;

    egg_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
    egg_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();

    assign m1.AWADDR  = m0.AWADDR;
    assign m1.AWPROT  = m0.AWPROT;
    assign m1.AWVALID = m0.AWVALID;
    assign m1.WDATA   = m0.WDATA;
    assign m1.WSTRB   = m0.WSTRB;
    assign m1.WVALID  = m0.WVALID;
    assign m1.BREADY  = m0.BREADY;
    assign m1.ARADDR  = m0.ARADDR;
    assign m1.ARPROT  = m0.ARPROT;
    assign m1.ARVALID = m0.ARVALID;
    assign m1.RREADY  = m0.RREADY;

    egg_axil_regfile #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK(4'b0000)) dut0 (
        .ACLK(clk), .ARESETN(rst_n), .S_AXI(m0), .ctrl_out(ctrl0), .status_in(status), .wr_pulse(pulse0));
    egg_axil_regfile #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK(4'b0100)) dut1 (
        .ACLK(clk), .ARESETN(rst_n), .S_AXI(m1), .ctrl_out(ctrl1), .status_in(status), .wr_pulse(pulse1));

    logic        o_awrdy [2], o_wrdy [2], o_arrdy [2], o_bvalid [2], o_rvalid [2];
    logic [1:0]  o_bresp [2], o_rresp [2];
    logic [31:0] o_rdata [2];
    logic [3:0]  o_pulse [2];
    logic [127:0] o_ctrl [2];
    assign o_awrdy[0] = m0.AWREADY;  assign o_awrdy[1] = m1.AWREADY;
    assign o_wrdy[0]  = m0.WREADY;   assign o_wrdy[1]  = m1.WREADY;
    assign o_arrdy[0] = m0.ARREADY;  assign o_arrdy[1] = m1.ARREADY;
    assign o_bvalid[0] = m0.BVALID;  assign o_bvalid[1] = m1.BVALID;
    assign o_rvalid[0] = m0.RVALID;  assign o_rvalid[1] = m1.RVALID;
    assign o_bresp[0] = m0.BRESP;    assign o_bresp[1] = m1.BRESP;
    assign o_rresp[0] = m0.RRESP;    assign o_rresp[1] = m1.RRESP;
    assign o_rdata[0] = m0.RDATA;    assign o_rdata[1] = m1.RDATA;
    assign o_pulse[0] = pulse0;      assign o_pulse[1] = pulse1;
    assign o_ctrl[0]  = ctrl0;       assign o_ctrl[1]  = ctrl1;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mdl [2][4];
    logic [3:0]  ro_mask1 = 4'b0100;

    typedef struct packed {
        logic [1:0][1:0]  resp;
        logic [1:0][31:0] data;
        logic [1:0][3:0]  pulse;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];

    function automatic logic is_ro(input int k, input int idx);
        return (k == 1) && ro_mask1[idx];
    endfunction

    function automatic exp_t model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        int idx;
        e = '0;
        idx = int'(addr[5:2]);
        for (int k = 0; k < 2; k++) begin
            e.resp[k] = (idx >= 4) ? 2'b10 : 2'b00;
            if (idx < 4 && !is_ro(k, idx)) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mdl[k][idx][b*8 +: 8] = data[b*8 +: 8];
                e.pulse[k] = 4'b0001 << idx;
            end
        end
        return e;
    endfunction

    function automatic exp_t model_read(input logic [5:0] addr);
        exp_t e;
        int idx;
        e = '0;
        idx = int'(addr[5:2]);
        for (int k = 0; k < 2; k++) begin
            if (idx >= 4) begin
                e.resp[k] = 2'b10;
                e.data[k] = 32'h0;
            end else begin
                e.resp[k] = 2'b00;
                e.data[k] = is_ro(k, idx) ? status[idx*32 +: 32] : mdl[k][idx];
            end
        end
        return e;
    endfunction

    function automatic logic [127:0] model_ctrl(input int k);
        return {mdl[k][3], mdl[k][2], mdl[k][1], mdl[k][0]};
    endfunction

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input bit release_b);
        exp_t e;
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        wq.push_back(model_write(addr, data, strb));
        m0.AWADDR = addr; m0.WDATA = data; m0.WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            m0.AWVALID = !aw_done && (cyc >= aw_dly);
            m0.WVALID  = !w_done && (cyc >= w_dly);
            aw_hs = m0.AWVALID && m0.AWREADY;
            w_hs  = m0.WVALID && m0.WREADY;
            @(posedge clk); #1;
            cyc++;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            if (!(aw_done && w_done)) begin
                n_checks++;
                if (m0.BVALID !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_bvalid addr=%h: got %b expected 0", addr, m0.BVALID);
                end
            end
        end
        m0.AWVALID = 1'b0; m0.WVALID = 1'b0;
        if (!(aw_done && w_done)) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout addr=%h: handshake not seen", addr);
        end
        e = wq.pop_front();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_bvalid[k] !== 1'b1 || o_bresp[k] !== e.resp[k]) begin
                n_fail++;
                $display("FAIL bresp dut%0d addr=%h: got bvalid=%b bresp=%b expected 1/%b", k, addr, o_bvalid[k], o_bresp[k], e.resp[k]);
            end
            n_checks++;
            if (o_pulse[k] !== e.pulse[k]) begin
                n_fail++;
                $display("FAIL wr_pulse dut%0d addr=%h: got %b expected %b", k, addr, o_pulse[k], e.pulse[k]);
            end
        end
        if (release_b) begin
            m0.BREADY = 1'b1;
            @(posedge clk); #1;
            m0.BREADY = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_bvalid[k] !== 1'b0 || o_pulse[k] !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL b_release dut%0d: got bvalid=%b pulse=%b expected 0/0000", k, o_bvalid[k], o_pulse[k]);
                end
            end
        end
    endtask

    task automatic do_read(input logic [5:0] addr);
        exp_t e;
        bit done, hs;
        int cyc;
        done = 1'b0; cyc = 0;
        rq.push_back(model_read(addr));
        m0.ARADDR = addr;
        while (!done && cyc < 40) begin
            m0.ARVALID = 1'b1;
            hs = m0.ARREADY;
            @(posedge clk); #1;
            cyc++;
            done = hs;
        end
        m0.ARVALID = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL read_timeout addr=%h: handshake not seen", addr);
        end
        e = rq.pop_front();
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_rvalid[k] !== 1'b1 || o_rdata[k] !== e.data[k] || o_rresp[k] !== e.resp[k]) begin
                    n_fail++;
                    $display("FAIL rdata dut%0d addr=%h hold=%0d: got v=%b d=%h r=%b expected 1/%h/%b",
                             k, addr, h, o_rvalid[k], o_rdata[k], o_rresp[k], e.data[k], e.resp[k]);
                end
            end
            m0.RREADY = (h == 1);
            @(posedge clk); #1;
        end
        m0.RREADY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_rvalid[k] !== 1'b0 || o_arrdy[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL r_release dut%0d: got rvalid=%b arready=%b expected 0/1", k, o_rvalid[k], o_arrdy[k]);
            end
        end
    endtask

    task automatic check_ctrl(input string tag);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_ctrl[k] !== model_ctrl(k)) begin
                n_fail++;
                $display("FAIL ctrl_out_%s dut%0d: got %h expected %h", tag, k, o_ctrl[k], model_ctrl(k));
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_awrdy[k], o_wrdy[k], o_arrdy[k], o_bvalid[k], o_rvalid[k]} !== 5'b0 ||
                o_bresp[k] !== 2'b00 || o_rresp[k] !== 2'b00 || o_rdata[k] !== 32'h0 ||
                o_ctrl[k] !== 128'h0 || o_pulse[k] !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: rdy=%b%b%b bv=%b rv=%b ctrl=%h expected all zero",
                         k, o_awrdy[k], o_wrdy[k], o_arrdy[k], o_bvalid[k], o_rvalid[k], o_ctrl[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_awrdy[k], o_wrdy[k], o_arrdy[k]} !== 3'b111) begin
                n_fail++;
                $display("FAIL ready_after_reset dut%0d: got %b%b%b expected 111", k, o_awrdy[k], o_wrdy[k], o_arrdy[k]);
            end
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) do_read(6'(i * 4));
        check_ctrl("seq");
    endtask

    task automatic test_strobe();
        do_write(6'h00, 32'hAABB_CCDD, 4'hF, 0, 0, 1'b1);
        do_write(6'h00, 32'h1122_3344, 4'b0101, 0, 0, 1'b1);
        do_read(6'h00);
    endtask

    task automatic test_ordering();
        do_write(6'h04, 32'h0000_5A5A, 4'hF, 3, 0, 1'b1);
        do_write(6'h0C, 32'h0000_C3C3, 4'hF, 0, 3, 1'b1);
        do_read(6'h04);
        do_read(6'h0C);
    endtask

    task automatic test_read_only();
        do_write(6'h08, 32'h0000_0005, 4'hF, 0, 0, 1'b1);
        do_read(6'h08);
    endtask

    task automatic test_out_of_range();
        do_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b1);
        do_read(6'h10);
        do_read(6'h3C);
        do_read(6'h07);
        check_ctrl("oor");
    endtask

    task automatic test_same_edge();
        exp_t er;
        er = model_read(6'h04);
        void'(model_write(6'h04, 32'h600D_0004, 4'hF));
        m0.AWADDR = 6'h04; m0.WDATA = 32'h600D_0004; m0.WSTRB = 4'hF; m0.ARADDR = 6'h04;
        m0.AWVALID = 1'b1; m0.WVALID = 1'b1; m0.ARVALID = 1'b1;
        @(posedge clk); #1;
        m0.AWVALID = 1'b0; m0.WVALID = 1'b0; m0.ARVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_rvalid[k] !== 1'b1 || o_rdata[k] !== er.data[k] || o_bvalid[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL same_edge dut%0d: got rv=%b rdata=%h bv=%b expected 1/%h/1", k, o_rvalid[k], o_rdata[k], o_bvalid[k], er.data[k]);
            end
        end
        m0.BREADY = 1'b1; m0.RREADY = 1'b1;
        @(posedge clk); #1;
        m0.BREADY = 1'b0; m0.RREADY = 1'b0;
        do_read(6'h04);
    endtask

    task automatic test_back_to_back();
        int acc;
        int hs_cyc [4];
        bit hs;
        acc = 0;
        m0.BREADY = 1'b1;
        for (int cyc = 0; cyc < 12 && acc < 4; cyc++) begin
            m0.AWADDR = 6'(acc * 4); m0.WDATA = 32'hB0B0_0000 + 32'(acc); m0.WSTRB = 4'hF;
            m0.AWVALID = 1'b1; m0.WVALID = 1'b1;
            hs = m0.AWREADY && m0.WREADY;
            @(posedge clk); #1;
            if (hs) begin
                void'(model_write(6'(acc * 4), 32'hB0B0_0000 + 32'(acc), 4'hF));
                hs_cyc[acc] = cyc;
                acc++;
            end
        end
        m0.AWVALID = 1'b0; m0.WVALID = 1'b0;
        @(posedge clk); #1;
        m0.BREADY = 1'b0;
        n_checks++;
        if (acc != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d writes accepted expected 4", acc);
        end
        for (int i = 1; i < acc; i++) begin
            n_checks++;
            if (hs_cyc[i] - hs_cyc[i-1] != 2) begin
                n_fail++;
                $display("FAIL b2b_spacing write%0d: got %0d cycles expected 2", i, hs_cyc[i] - hs_cyc[i-1]);
            end
        end
        for (int i = 0; i < 4; i++) do_read(6'(i * 4));
    endtask

    task automatic test_reset_mid();
        do_write(6'h04, 32'h0000_0099, 4'hF, 0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_bvalid[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL bvalid_hold dut%0d: got %b expected 1", k, o_bvalid[k]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) mdl[k][i] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_bvalid[k] !== 1'b0 || o_ctrl[k] !== 128'h0 || o_awrdy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got bv=%b ctrl=%h awrdy=%b expected 0/0/0", k, o_bvalid[k], o_ctrl[k], o_awrdy[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_write(6'h00, 32'h0000_0007, 4'hF, 0, 0, 1'b1);
        do_read(6'h00);
        do_read(6'h04);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) mdl[k][i] = 32'h0;
        status = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0F0F_0F0F};
        m0.AWADDR = 6'h00; m0.AWPROT = 3'b000; m0.AWVALID = 1'b0;
        m0.WDATA = 32'h0; m0.WSTRB = 4'h0; m0.WVALID = 1'b0; m0.BREADY = 1'b0;
        m0.ARADDR = 6'h00; m0.ARPROT = 3'b000; m0.ARVALID = 1'b0; m0.RREADY = 1'b0;
        test_reset();
        test_sequential();
        test_strobe();
        test_ordering();
        test_read_only();
        test_out_of_range();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/egg_axil_regfile.md
# egg_axil_regfile

Parametrised AXI4-Lite slave register file for the EggNet IP control/status space, generalising the fixed four-register 32-bit slave interface. It supports a configurable register count and data width, byte-lane write strobes, and hardware-owned read-only status registers. It also reports out-of-range accesses with SLVERR and emits a per-register write pulse to the accelerator core. It sits between the block-design AXI interconnect and the EggNet datapath control logic.

## Interface
- NUM_REGS, 4, number of registers; 1..64
- DATA_WIDTH, 32, AXI data width; 32 or 64
- ADDR_WIDTH, 6, AXI address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8
- RO_MASK, '0, NUM_REGS-bit mask; bit i set = register i read-only, value taken from status_in
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous assert, active-low
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_WIDTH/3/1  write address channel; AWPROT ignored
- S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
- S_AXI_WREADY  out  1
- S_AXI_BRESP/BVALID  out  2/1, S_AXI_BREADY in 1  write response
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_WIDTH/3/1, S_AXI_ARREADY out 1  read address; ARPROT ignored
- S_AXI_RDATA/RRESP/RVALID  out  DATA_WIDTH/2/1, S_AXI_RREADY in 1  read data
- ctrl_out  out  NUM_REGS*DATA_WIDTH  flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
- status_in  in  NUM_REGS*DATA_WIDTH  status values; only RO_MASK lanes used
- wr_pulse  out  NUM_REGS  one-cycle strobe, bit i high the cycle after register i is written

## Operation
- Index = addr[ADDR_WIDTH-1:ADDR_LSB], ADDR_LSB = clog2(DATA_WIDTH/8); low address bits are ignored.
- Index >= NUM_REGS: write has no effect, BRESP=SLVERR (2'b10); read returns RDATA=0, RRESP=SLVERR.
- Write to an RW register: only lanes with WSTRB bit set are updated; BRESP=OKAY; wr_pulse[i] asserted.
- Write to an RO register: data discarded, no wr_pulse, BRESP=OKAY.
- Read of an RO register returns status_in lane, sampled at AR handshake; RW returns stored value.
- Write FSM: W_IDLE -> (AW and/or W latched independently, either order) -> W_RESP once both are held -> W_IDLE on BVALID&&BREADY.
- Read FSM: R_IDLE -> R_DATA on AR handshake -> R_IDLE on RVALID&&RREADY.
- Read and write channels are fully independent; one outstanding transaction per channel.

## Timing
- Reset: AWREADY=WREADY=ARREADY=0 while ARESETN low, 1 from the first edge after release; BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, ctrl_out=0, wr_pulse=0.
- AWREADY high iff no AW is latched and BVALID low; WREADY likewise for W. Same-cycle AW+W is accepted.
- Register update, BVALID and wr_pulse all assert on the edge after the later of the AW/W handshakes. BVALID and BRESP hold until BREADY; wr_pulse lasts exactly 1 cycle.
- ARREADY = !RVALID. RVALID and RDATA are registered 1 cycle after AR handshake and hold stable until RREADY.
- Read and write to the same register resolving on the same edge: read returns the pre-write value.
- Back-to-back: with BREADY/RREADY tied high, a new write or read is accepted every 2 cycles.
- ARESETN asserted mid-transaction aborts immediately; all state returns to reset values and no partial write is kept.

## Structure
- Package egg_axil_pkg: RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants, write/read state enums, addr_lsb(DATA_WIDTH) function.
- Single module; no sub-module needed. Strobe merge is a generate loop over byte lanes.

## Test plan
- Sequential write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC (NUM_REGS=4, 32-bit), then read back -> RDATA 0x1..0x4, all RESP=OKAY, wr_pulse one-hot each write.
- Reg0=0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> read 0xAA22CC44.
- W presented 3 cycles before AW, then AW before W -> both accepted, BVALID 1 cycle after the second handshake.
- RO_MASK=4'b0100, status_in lane2=0xDEADBEEF, write 0x5 to 0x8 -> BRESP=OKAY, no wr_pulse, read 0x8 -> 0xDEADBEEF.
- Write and read address 0x10 (index 4, out of range) -> BRESP=SLVERR, RDATA=0, RRESP=SLVERR, registers unchanged.
- BREADY held low 10 cycles, then ARESETN pulsed low -> BVALID drops asynchronously, ctrl_out=0; next write at 0x0 of 0x7 -> reads back 0x7.
